// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Summary  : PC holder issuing one-outstanding word fetches and presenting the
//            fetched instruction/PC/opcode to decode. Optional one-entry skid
//            buffer with fetch overlap when FETCH_OVERLAP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  output logic [5:0]      opcode,
  input  logic            redir_valid,
  input  logic [PC_W-1:0] redir_pc
);

  localparam logic [PC_W-1:0] c_pc_step = PC_W'(4);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_outstanding;
  logic            r_discard;
  logic            r_imem_req;
  logic [PC_W-1:0] r_imem_addr;
  logic            r_inst_valid;
  logic [31:0]     r_inst;
  logic [PC_W-1:0] r_inst_pc;
  logic [5:0]      r_opcode;

  state_t          w_state_next;
  logic            w_rsp;
  logic            w_hs;
  logic            w_take;
  logic            w_out_keep;
  logic            w_issue;
  logic            w_discard_next;
  logic [PC_W-1:0] w_pc_next;
  logic            w_valid_next;
  logic [31:0]     w_inst_next;
  logic [PC_W-1:0] w_inst_pc_next;
  logic            w_unused_redir_lsb;

`ifdef FETCH_OVERLAP_EN
  logic            r_skid_valid;
  logic [31:0]     r_skid;
  logic [PC_W-1:0] r_skid_pc;
  logic            w_skid_valid_next;
  logic [31:0]     w_skid_next;
  logic [PC_W-1:0] w_skid_pc_next;
`endif

  assign w_unused_redir_lsb = ^redir_pc[1:0];

  always_comb begin
    w_rsp          = imem_rvalid & r_outstanding;
    w_hs           = (r_state == S_HOLD) & inst_ready;
    w_take         = w_rsp & ~r_discard & ~redir_valid;
    w_out_keep     = r_outstanding & ~w_rsp;
    w_discard_next = r_discard & ~w_rsp;
    w_pc_next      = r_pc;
    w_valid_next   = r_inst_valid;
    w_inst_next    = r_inst;
    w_inst_pc_next = r_inst_pc;
`ifdef FETCH_OVERLAP_EN
    w_skid_valid_next = r_skid_valid;
    w_skid_next       = r_skid;
    w_skid_pc_next    = r_skid_pc;
`endif

    if (redir_valid) begin
      // A still-pending response must be swallowed when it finally arrives.
      w_pc_next      = {redir_pc[PC_W-1:2], 2'b00};
      w_valid_next   = 1'b0;
      w_discard_next = w_out_keep;
`ifdef FETCH_OVERLAP_EN
      w_skid_valid_next = 1'b0;
`endif
    end else begin
      if (w_take) begin
        w_pc_next = r_pc + c_pc_step;
      end
      if (w_hs || !r_inst_valid) begin
        w_valid_next = 1'b0;
`ifdef FETCH_OVERLAP_EN
        if (r_skid_valid) begin
          w_valid_next      = 1'b1;
          w_inst_next       = r_skid;
          w_inst_pc_next    = r_skid_pc;
          w_skid_valid_next = 1'b0;
        end else if (w_take) begin
`else
        if (w_take) begin
`endif
          w_valid_next   = 1'b1;
          w_inst_next    = imem_rdata;
          w_inst_pc_next = r_pc;
        end
      end
`ifdef FETCH_OVERLAP_EN
      else if (w_take) begin
        w_skid_valid_next = 1'b1;
        w_skid_next       = imem_rdata;
        w_skid_pc_next    = r_pc;
      end
`endif
    end

`ifdef FETCH_OVERLAP_EN
    w_issue = !w_out_keep && !w_skid_valid_next;
`else
    w_issue = !w_out_keep && !w_valid_next;
`endif

    if (w_valid_next) begin
      w_state_next = S_HOLD;
    end else if (w_out_keep || w_issue) begin
      w_state_next = S_WAIT;
    end else begin
      w_state_next = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= RESET_PC;
      r_inst_valid  <= 1'b0;
      r_inst        <= 32'd0;
      r_inst_pc     <= RESET_PC;
      r_opcode      <= 6'd0;
`ifdef FETCH_OVERLAP_EN
      r_skid_valid  <= 1'b0;
      r_skid        <= 32'd0;
      r_skid_pc     <= RESET_PC;
`endif
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_outstanding <= w_out_keep | w_issue;
      r_discard     <= w_discard_next;
      r_imem_req    <= w_issue;
      if (w_issue) begin
        r_imem_addr <= w_pc_next;
      end
      r_inst_valid  <= w_valid_next;
      r_inst        <= w_inst_next;
      r_inst_pc     <= w_inst_pc_next;
      r_opcode      <= w_valid_next ? w_inst_next[31:26] : 6'd0;
`ifdef FETCH_OVERLAP_EN
      r_skid_valid  <= w_skid_valid_next;
      r_skid        <= w_skid_next;
      r_skid_pc     <= w_skid_pc_next;
`endif
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_imem_addr;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign opcode     = r_opcode;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// Directed bench for instr_fetch with a latency-programmable instruction memory model.
module tb_instr_fetch;

`ifdef FETCH_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [5:0]  opcode;
  logic        redir_valid;
  logic [31:0] redir_pc;

  int          n_checks = 0;
  int          n_errors = 0;

  int          mem_lat   = 1;
  int          pend      = 0;
  logic [31:0] pend_addr = 32'd0;
  int          req_cnt   = 0;
  bit          ovr_en    = 1'b0;
  logic [31:0] ovr_data  = 32'd0;
  bit          inject    = 1'b0;

  instr_fetch #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .opcode      (opcode),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {a[7:2], 26'h2AB_CDE};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      if (imem_req) break;
      step();
    end
    chk(tag, 32'(imem_req), 32'd1);
  endtask

  task automatic wait_valid(input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      if (inst_valid) break;
      step();
    end
    chk(tag, 32'(inst_valid), 32'd1);
  endtask

  task automatic do_reset(input int lat);
    rst_n       = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 32'd0;
    inst_ready  = 1'b0;
    ovr_en      = 1'b0;
    inject      = 1'b0;
    mem_lat     = lat;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(imem_req),   32'd0);
    chk({tag, "_addr"},  imem_addr,       32'd0);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"},  inst,            32'd0);
    chk({tag, "_pc"},    inst_pc,         32'd0);
    chk({tag, "_opc"},   32'(opcode),     32'd0);
  endtask

  // Memory: a request seen in cycle c is answered in cycle c+mem_lat.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (!rst_n) pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = ovr_en ? ovr_data : mem_word(pend_addr);
        end
      end
      if (inject) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
      end
      if (imem_req) begin
        req_cnt++;
        pend      = mem_lat;
        pend_addr = imem_addr;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  base;
    bit  stable;
    rst_n       = 1'b0;
    inst_ready  = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 32'd0;
    step();
    step();
    chk_reset_outputs("rst");

    // Reset release, L=1, first instruction and next fetch address
    do_reset(1);
    inst_ready = 1'b1;
    chk("t1_req_c0",  32'(imem_req), 32'd1);
    chk("t1_addr_c0", imem_addr,     32'h0);
    step();
    chk("t1_valid_c1", 32'(inst_valid), 32'd0);
    chk("t1_opc_c1",   32'(opcode),     32'd0);
    step();
    chk("t1_valid_c2", 32'(inst_valid), 32'd1);
    chk("t1_pc_c2",    inst_pc,         32'h0);
    chk("t1_opc_c2",   32'(opcode),     32'h08);
    chk("t1_inst_c2",  inst,            32'h2008_0005);
    chk("t1_req_c2",   32'(imem_req),   32'(OVL));
    wait_req(4, "t1_next_req");
    chk("t1_next_addr", imem_addr, 32'h4);

    // Decode stall for 5 cycles, L=2
    do_reset(2);
    base = req_cnt;
    step();
    step();
    step();
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(inst_valid && inst == 32'h2008_0005 && inst_pc == 32'h0)) stable = 1'b0;
      if (i < 4) step();
    end
    chk("t2_hold_stable", 32'(stable), 32'd1);
    chk("t2_extra_reqs", 32'(req_cnt - base), OVL ? 32'd1 : 32'd0);
    inst_ready = 1'b1;
    step();
    chk("t2_valid_after",  32'(inst_valid), 32'(OVL));
    chk("t2_pc_after",     inst_pc,         OVL ? 32'h4 : 32'h0);
    chk("t2_opc_after",    32'(opcode),     OVL ? 32'h01 : 32'h00);
    chk("t2_req_after",    32'(imem_req),   32'd1);
    chk("t2_addr_after",   imem_addr,       OVL ? 32'h8 : 32'h4);

    // Redirect while waiting on a response, L=3
    do_reset(3);
    inst_ready = 1'b1;
    step();
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0043;
    step();
    redir_valid = 1'b0;
    chk("t3_valid_c2", 32'(inst_valid), 32'd0);
    chk("t3_req_c2",   32'(imem_req),   32'd0);
    step();
    step();
    chk("t3_req_c4",   32'(imem_req),   32'd1);
    chk("t3_addr_c4",  imem_addr,       32'h40);
    chk("t3_valid_c4", 32'(inst_valid), 32'd0);
    wait_valid(8, "t3_valid_wait");
    chk("t3_first_pc",   inst_pc,     32'h40);
    chk("t3_first_opc",  32'(opcode), 32'h10);
    chk("t3_first_inst", inst,        mem_word(32'h40));

    // Redirect in the same cycle as the response, L=2
    do_reset(2);
    inst_ready = 1'b1;
    ovr_en     = 1'b1;
    ovr_data   = 32'h1000_FFFF;
    step();
    step();
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0100;
    step();
    redir_valid = 1'b0;
    ovr_en      = 1'b0;
    chk("t4_valid_c3", 32'(inst_valid), 32'd0);
    chk("t4_opc_c3",   32'(opcode),     32'd0);
    chk("t4_req_c3",   32'(imem_req),   32'd1);
    chk("t4_addr_c3",  imem_addr,       32'h100);
    step();
    chk("t4_valid_c4", 32'(inst_valid), 32'd0);
    wait_valid(6, "t4_valid_wait");
    chk("t4_first_pc",   inst_pc, 32'h100);
    chk("t4_first_inst", inst,    mem_word(32'h100));

    // PC wrap from the top of the address space, L=1
    do_reset(1);
    step();
    step();
    redir_valid = 1'b1;
    redir_pc    = 32'hFFFF_FFFE;
    step();
    redir_valid = 1'b0;
    wait_req(4, "t5_req_top");
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    wait_valid(6, "t5_valid_top");
    chk("t5_pc_top",  inst_pc,     32'hFFFF_FFFC);
    chk("t5_opc_top", 32'(opcode), 32'h3F);
    inst_ready = 1'b1;
    wait_req(4, "t5_req_wrap");
    chk("t5_addr_wrap", imem_addr, 32'h0);

    // Asynchronous reset while holding, late response after release, L=3
    do_reset(3);
    step();
    step();
    step();
    step();
    chk("t6_valid_c4",  32'(inst_valid), 32'd1);
    chk("t6_skid_req",  32'(imem_req),   32'(OVL));
    step();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    inject = 1'b1;
    step();
    inject = 1'b0;
    rst_n  = 1'b1;
    step();
    chk("t6_req_c0",   32'(imem_req),   32'd1);
    chk("t6_addr_c0",  imem_addr,       32'h0);
    chk("t6_valid_c0", 32'(inst_valid), 32'd0);
    wait_valid(8, "t6_valid_wait");
    chk("t6_inst", inst,    32'h2008_0005);
    chk("t6_pc",   inst_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the producer end of the opcode interface that feeds the main control decoder. It holds the PC and issues word fetches to instruction memory with a one-outstanding request/response handshake. It presents each fetched instruction, its PC and its 6-bit opcode to decode under a valid/ready handshake. It accepts branch/jump redirects, which flush any in-flight or held instruction.

## Interface
- `PC_W`, 32: PC and instruction-memory address width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  single-cycle fetch request strobe.
- `imem_addr`  out  PC_W  word address of the request; valid while `imem_req`=1.
- `imem_rvalid`  in  1  response strobe, at least 1 cycle after `imem_req`.
- `imem_rdata`  in  32  instruction word; valid with `imem_rvalid`.
- `inst_valid`  out  1  `inst`/`inst_pc`/`opcode` are valid.
- `inst_ready`  in  1  decode accepts the instruction.
- `inst`  out  32  held instruction word.
- `inst_pc`  out  PC_W  address of `inst`.
- `opcode`  out  6  `inst[31:26]`; forced to 0 when `inst_valid`=0.
- `redir_valid`  in  1  branch-taken or jump redirect.
- `redir_pc`  in  PC_W  redirect target; bits [1:0] are ignored and treated as 00.

## Operation
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0, `inst`=0, `inst_pc`=RESET_PC, `opcode`=0. Internal state: fetch PC=RESET_PC, outstanding=0, discard=0, state=FETCH.
- FSM states:
  - FETCH: assert `imem_req`, `imem_addr`=fetch PC; go to WAIT.
  - WAIT: on `imem_rvalid`, capture `imem_rdata`, set `inst_valid`, fetch PC += 4, go to HOLD.
  - HOLD: on `inst_valid & inst_ready`, clear `inst_valid`, go to FETCH.
- Only one request is ever outstanding. A new `imem_req` is never issued while a response is pending.
- PC arithmetic is modulo 2^PC_W: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000. Bits [1:0] of the fetch PC are always 0.
- Redirect (`redir_valid`=1 in any state):
  - Fetch PC <= {redir_pc[PC_W-1:2],2'b00}.
  - `inst_valid` and the skid entry are cleared at the next edge.
  - If a response is outstanding and does not arrive in the same cycle, set discard. The next response is dropped and clears discard; the FSM then goes to FETCH.
  - Otherwise the FSM goes to FETCH.
- Simultaneous events:
  - Redirect + `imem_rvalid`: the response is dropped.
  - Redirect + handshake: the instruction counts as consumed, then flushed state applies.
  - Redirect + `imem_req`: that request becomes outstanding with discard=1.
  - Back-to-back redirects: the last one wins.
- Reset asserted mid-operation returns all state to reset values immediately. Any late `imem_rvalid` after reset release while no request is outstanding is ignored.

## Timing
- Cycle 0 = first edge with `rst_n`=1: `imem_req`=1, `imem_addr`=RESET_PC.
- Memory latency L (response in cycle 0+L): `inst_valid`=1 in cycle L+1.
- Without overlap: handshake in cycle h gives the next `imem_req` in cycle h+1. Throughput is one instruction per L+2 cycles with ready held high.
- Redirect in cycle r with nothing outstanding: `imem_req` at the new PC in cycle r+1. If a request is outstanding, the new request goes out the cycle after the dropped response.
- No combinational path from `imem_rvalid`/`imem_rdata` to any decode-side output. `opcode` is decoded from the `inst` register.

## Configuration
- `FETCH_OVERLAP_EN` defined:
  - Adds a one-entry skid buffer. In HOLD, the next request is issued immediately instead of waiting for the handshake.
  - A response arriving while `inst_valid`=1 and not being consumed goes to the skid entry. No further request is issued while the skid is full.
  - On handshake, the skid entry moves to `inst` in the next cycle, and the next request is issued the same cycle.
  - A response arriving in the handshake cycle goes straight to `inst`.
  - With L=1 and ready high: one instruction per 2 cycles.
- Undefined: no skid register. Behaviour is exactly the FETCH/WAIT/HOLD sequence above.

## Test plan
- Reset release with L=1, mem[0]=32'h2008_0005, `inst_ready`=1: `imem_req` in cycle 0 with addr 0. In cycle 2: `inst_valid`=1, `inst_pc`=0, `opcode`=6'h08. Next req addr=4.
- `inst_ready`=0 for 5 cycles with L=2: `inst`/`inst_pc` held stable. No second `imem_req` without the macro; exactly one extra req, then stall, with the macro.
- Redirect to 32'h0000_0043 while WAIT with L=3: the old response is dropped, next `imem_addr`=32'h40, and no stale instruction reaches decode.
- Redirect and `imem_rvalid` in the same cycle, rdata=32'h1000_FFFF: dropped. `inst_valid` stays 0, next req to the redirect PC.
- Fetch PC=32'hFFFF_FFFC: after capture, the next req addr is 32'h0000_0000.
- Assert `rst_n`=0 while HOLD with an outstanding skid request: all outputs return to reset values asynchronously. A late `imem_rvalid` after release is ignored and the first req is to RESET_PC.
